ddr_wr_arbiter: RTL and testbench

//  Shares the single DDR controller write port among CH_NUM video write buffers (one per input channel).

---
 rtl/ddr_wr_arbiter_pkg.sv | 23 ++
 rtl/ddr_wr_arbiter_rr_pick.sv | 47 ++++
 rtl/ddr_wr_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_ddr_wr_arbiter.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_wr_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// ddr_wr_arbiter_pkg
// Shared definitions for the DDR write-port arbiter: FSM state encoding, the
// width of the externally visible grant index, and the round-robin pointer
// advance helper.
// -----------------------------------------------------------------------------
package ddr_wr_arbiter_pkg;

    // grant_id is always presented on 3 bits, zero-extended for small CH_NUM.
    localparam int GRANT_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DATA = 2'd2
    } arb_state_e;

    // Next round-robin start position after channel idx was served.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
    endfunction

endpackage

// File: rtl/ddr_wr_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker: returns the first requesting channel at or
// after i_ptr, wrapping from CH_NUM-1 back to 0.
// Ports:
//   i_req   [CH_NUM]  request vector (already masked by enables)
//   i_ptr   [PTR_W]   round-robin start position
//   o_valid           at least one request is set
//   o_idx   [PTR_W]   chosen channel (0 when o_valid is low)
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter int CH_NUM = 4,
    parameter int PTR_W  = $clog2(CH_NUM)
) (
    input  logic [CH_NUM-1:0] i_req,
    input  logic [PTR_W-1:0]  i_ptr,
    output logic              o_valid,
    output logic [PTR_W-1:0]  o_idx
);

    int w_dist;
    int w_best;

    // Each channel's distance from the pointer (mod CH_NUM) is its priority;
    // the smallest distance among requesters wins. Iterating with constant
    // indices keeps the request vector free of variable bit-selects.
    always_comb begin
        // NOTE: every output gets a default before any branch so no path can
        // leave it unassigned and infer a latch.
        o_valid = 1'b0;
        o_idx   = '0;
        w_best  = CH_NUM;
        w_dist  = 0;
        for (int c = 0; c < CH_NUM; c++) begin
            w_dist = c - int'(i_ptr);
            if (w_dist < 0) begin
                w_dist = w_dist + CH_NUM;
            end
            if (i_req[c] && (w_dist < w_best)) begin
                w_best  = w_dist;
                o_valid = 1'b1;
                o_idx   = PTR_W'(c);
            end
        end
    end

endmodule

// File: rtl/ddr_wr_arbiter.sv
// -----------------------------------------------------------------------------
// ddr_wr_arbiter
// Shares the single DDR controller write port among CH_NUM write buffers.
// A channel is granted round-robin, its address/length are latched and its
// burst is forwarded; controller strobes are routed back to the granted channel.
// Ports (all in i_ddr_clk):
//   i_ddr_clk, i_ddr_rst       clock, synchronous active-high reset
//   i_ch_en/i_ch_wreq [CH]     per-channel enable and level write request
//   i_ch_waddr/_wr_len/_wdata  packed per-channel address, length, data
//   o_ch_wrdy/_wdata_req/_wdone  controller strobes routed to granted channel
//   o_ddr_wreq/_waddr/_wr_len  latched request towards the controller
//   i_ddr_wrdy/_wdata_req/_wdone controller handshake inputs
//   o_ddr_wdata                data of the granted channel (0 when idle)
//   o_grant_id [3]             current/last granted channel
//   o_busy                     FSM not idle
//   o_timeout_err              sticky: burst exceeded TIMEOUT_CYC cycles
// -----------------------------------------------------------------------------
module ddr_wr_arbiter
    import ddr_wr_arbiter_pkg::*;
#(
    parameter int CH_NUM      = 4,
    parameter int ADDR_WIDTH  = 27,
    parameter int LEN_WIDTH   = 16,
    parameter int DQ_WIDTH    = 16,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                             i_ddr_clk,
    input  logic                             i_ddr_rst,
    input  logic [CH_NUM-1:0]                i_ch_en,
    input  logic [CH_NUM-1:0]                i_ch_wreq,
    input  logic [CH_NUM*ADDR_WIDTH-1:0]     i_ch_waddr,
    input  logic [CH_NUM*LEN_WIDTH-1:0]      i_ch_wr_len,
    input  logic [CH_NUM*8*DQ_WIDTH-1:0]     i_ch_wdata,
    output logic [CH_NUM-1:0]                o_ch_wrdy,
    output logic [CH_NUM-1:0]                o_ch_wdata_req,
    output logic [CH_NUM-1:0]                o_ch_wdone,
    output logic                             o_ddr_wreq,
    output logic [ADDR_WIDTH-1:0]            o_ddr_waddr,
    output logic [LEN_WIDTH-1:0]             o_ddr_wr_len,
    input  logic                             i_ddr_wrdy,
    output logic [8*DQ_WIDTH-1:0]            o_ddr_wdata,
    input  logic                             i_ddr_wdata_req,
    input  logic                             i_ddr_wdone,
    output logic [GRANT_W-1:0]               o_grant_id,
    output logic                             o_busy,
    output logic                             o_timeout_err
);

    localparam int DATA_W = 8 * DQ_WIDTH;
    localparam int PTR_W  = $clog2(CH_NUM);
    localparam int TMR_W  = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT_CYC - 1);

    arb_state_e             r_state;
    arb_state_e             w_state_nxt;
    logic                   r_ddr_wreq;
    logic [ADDR_WIDTH-1:0]  r_waddr;
    logic [LEN_WIDTH-1:0]   r_len;
    logic [GRANT_W-1:0]     r_grant_id;
    logic [PTR_W-1:0]       r_rr_ptr;
    logic [TMR_W-1:0]       r_timer;
    logic                   r_timeout_err;

    logic [CH_NUM-1:0]      w_eligible;
    logic                   w_pick_valid;
    logic [PTR_W-1:0]       w_pick_idx;
    logic [ADDR_WIDTH-1:0]  w_sel_addr;
    logic [LEN_WIDTH-1:0]   w_sel_len;
    logic                   w_burst_done;
    logic [PTR_W-1:0]       w_ptr_nxt;

    assign w_eligible = i_ch_wreq & i_ch_en;

    rr_pick #(
        .CH_NUM (CH_NUM),
        .PTR_W  (PTR_W)
    ) u_rr_pick (
        .i_req   (w_eligible),
        .i_ptr   (r_rr_ptr),
        .o_valid (w_pick_valid),
        .o_idx   (w_pick_idx)
    );

    // Address/length of the channel the picker would grant this cycle.
    always_comb begin
        w_sel_addr = '0;
        w_sel_len  = '0;
        for (int c = 0; c < CH_NUM; c++) begin
            if (w_pick_idx == PTR_W'(c)) begin
                w_sel_addr = i_ch_waddr[c*ADDR_WIDTH +: ADDR_WIDTH];
                w_sel_len  = i_ch_wr_len[c*LEN_WIDTH +: LEN_WIDTH];
            end
        end
    end

    // A burst ends on ddr_wdone in DATA, or in REQ when the first data strobe
    // and the done pulse coincide.
    assign w_burst_done = ((r_state == ST_DATA) && i_ddr_wdone) ||
                          ((r_state == ST_REQ) && i_ddr_wdata_req && i_ddr_wdone);

    assign w_ptr_nxt = PTR_W'(rr_next(32'(r_grant_id), CH_NUM));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_pick_valid) w_state_nxt = ST_REQ;
            ST_REQ:  if (i_ddr_wdata_req) w_state_nxt = i_ddr_wdone ? ST_IDLE : ST_DATA;
            ST_DATA: if (i_ddr_wdone) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_ddr_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register here sees the pre-edge value of every other register.
        if (i_ddr_rst) begin
            r_state       <= ST_IDLE;
            r_ddr_wreq    <= 1'b0;
            r_waddr       <= '0;
            r_len         <= '0;
            r_grant_id    <= '0;
            r_rr_ptr      <= '0;
            r_timer       <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state <= w_state_nxt;

            // Latch the burst parameters at grant; later input changes are ignored.
            if ((r_state == ST_IDLE) && w_pick_valid) begin
                r_grant_id <= GRANT_W'(w_pick_idx);
                r_waddr    <= w_sel_addr;
                r_len      <= w_sel_len;
                r_ddr_wreq <= 1'b1;
            end

            if ((r_state == ST_REQ) && i_ddr_wdata_req) begin
                r_ddr_wreq <= 1'b0;
            end

            if (w_burst_done) begin
                r_rr_ptr <= w_ptr_nxt;
            end

            // Timer saturates at its limit; the burst is never aborted, only flagged.
            if (r_state == ST_IDLE) begin
                r_timer <= '0;
            end else if (r_timer != TMR_MAX) begin
                r_timer <= r_timer + TMR_W'(1);
            end else begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    // Strobe and data routing: combinational, only while a burst is owned.
    always_comb begin
        o_ch_wrdy      = '0;
        o_ch_wdata_req = '0;
        o_ch_wdone     = '0;
        o_ddr_wdata    = '0;
        if (r_state != ST_IDLE) begin
            for (int c = 0; c < CH_NUM; c++) begin
                if (r_grant_id == GRANT_W'(c)) begin
                    o_ddr_wdata       = i_ch_wdata[c*DATA_W +: DATA_W];
                    o_ch_wrdy[c]      = i_ddr_wrdy;
                    o_ch_wdata_req[c] = i_ddr_wdata_req;
                    o_ch_wdone[c]     = i_ddr_wdone;
                end
            end
        end
    end

    assign o_ddr_wreq    = r_ddr_wreq;
    assign o_ddr_waddr   = r_waddr;
    assign o_ddr_wr_len  = r_len;
    assign o_grant_id    = r_grant_id;
    assign o_busy        = (r_state != ST_IDLE);
    assign o_timeout_err = r_timeout_err;

endmodule

// File: tb/tb_ddr_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_ddr_wr_arbiter
// Drives the arbiter with channel requests and a scripted DDR controller, and
// compares every observable against a transaction-level reference: a
// round-robin pointer, the channel values at grant time, and a cycle count
// since grant for the timeout flag.
// -----------------------------------------------------------------------------
module tb_ddr_wr_arbiter;

    localparam int CH = 4;
    localparam int AW = 27;
    localparam int LW = 16;
    localparam int DQ = 16;
    localparam int DW = 8 * DQ;
    localparam int TO = 4096;

    logic clk = 1'b0;
    logic rst;

    logic [CH-1:0] req;
    logic [CH-1:0] en;
    logic [AW-1:0] addr [CH];
    logic [LW-1:0] len  [CH];
    logic [DW-1:0] data [CH];

    logic [CH*AW-1:0] bus_addr;
    logic [CH*LW-1:0] bus_len;
    logic [CH*DW-1:0] bus_data;

    logic ddr_wrdy;
    logic ddr_wdata_req;
    logic ddr_wdone;

    logic [CH-1:0] ch_wrdy;
    logic [CH-1:0] ch_wdata_req;
    logic [CH-1:0] ch_wdone;
    logic          ddr_wreq;
    logic [AW-1:0] ddr_waddr;
    logic [LW-1:0] ddr_wr_len;
    logic [DW-1:0] ddr_wdata;
    logic [2:0]    grant_id;
    logic          busy;
    logic          timeout_err;

    int  errors = 0;
    int  checks = 0;
    int  cyc    = 0;
    int  m_ptr  = 0;
    logic m_err = 1'b0;

    always #5 clk = ~clk;

    always_comb begin
        bus_addr = '0;
        bus_len  = '0;
        bus_data = '0;
        for (int c = 0; c < CH; c++) begin
            bus_addr[c*AW +: AW] = addr[c];
            bus_len[c*LW +: LW]  = len[c];
            bus_data[c*DW +: DW] = data[c];
        end
    end

    ddr_wr_arbiter #(
        .CH_NUM      (CH),
        .ADDR_WIDTH  (AW),
        .LEN_WIDTH   (LW),
        .DQ_WIDTH    (DQ),
        .TIMEOUT_CYC (TO)
    ) dut (
        .i_ddr_clk       (clk),
        .i_ddr_rst       (rst),
        .i_ch_en         (en),
        .i_ch_wreq       (req),
        .i_ch_waddr      (bus_addr),
        .i_ch_wr_len     (bus_len),
        .i_ch_wdata      (bus_data),
        .o_ch_wrdy       (ch_wrdy),
        .o_ch_wdata_req  (ch_wdata_req),
        .o_ch_wdone      (ch_wdone),
        .o_ddr_wreq      (ddr_wreq),
        .o_ddr_waddr     (ddr_waddr),
        .o_ddr_wr_len    (ddr_wr_len),
        .i_ddr_wrdy      (ddr_wrdy),
        .o_ddr_wdata     (ddr_wdata),
        .i_ddr_wdata_req (ddr_wdata_req),
        .i_ddr_wdone     (ddr_wdone),
        .o_grant_id      (grant_id),
        .o_busy          (busy),
        .o_timeout_err   (timeout_err)
    );

    task automatic check(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Reference arbitration: first eligible channel at or after the pointer.
    function automatic int model_pick();
        for (int off = 0; off < CH; off++) begin
            int c;
            c = (m_ptr + off) % CH;
            if (req[c] && en[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [CH-1:0] onehot(input int g);
        return CH'(1) << g;
    endfunction

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    // Advance one cycle inside a burst and check the sticky timeout flag:
    // it must be set once the burst has been outstanding for TO cycles.
    task automatic burst_tick();
        tick();
        if (cyc >= TO) m_err = 1'b1;
        check("timeout_err", timeout_err, m_err);
    endtask

    task automatic randomize_data();
        for (int c = 0; c < CH; c++) data[c] = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic rand_arrivals(input int g);
        for (int c = 0; c < CH; c++) begin
            if (c != g && !req[c] && $urandom_range(0, 7) == 0) begin
                req[c]  = 1'b1;
                addr[c] = AW'($urandom);
                len[c]  = LW'($urandom_range(1, 6));
            end
        end
    endtask

    task automatic idle_ctrl();
        ddr_wdata_req = 1'b0;
        ddr_wdone     = 1'b0;
        ddr_wrdy      = 1'b1;
    endtask

    task automatic idle_check(input string tag);
        randomize_data();
        #1;
        check({tag, ".busy"},      busy, 1'b0);
        check({tag, ".wreq"},      ddr_wreq, 1'b0);
        check({tag, ".ch_wrdy"},   ch_wrdy, '0);
        check({tag, ".ch_wdreq"},  ch_wdata_req, '0);
        check({tag, ".ch_wdone"},  ch_wdone, '0);
        check({tag, ".ddr_wdata"}, ddr_wdata, '0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_ctrl();
        tick();
        tick();
        rst   = 1'b0;
        m_ptr = 0;
        m_err = 1'b0;
        idle_check("reset");
        check("reset.grant_id", grant_id, 3'd0);
        check("reset.waddr", ddr_waddr, '0);
        check("reset.wr_len", ddr_wr_len, '0);
        check("reset.timeout_err", timeout_err, 1'b0);
    endtask

    // One complete burst from an IDLE negedge with requests already applied.
    // pre: cycles before the first data strobe; gap: cycles between last beat
    // and ddr_wdone; merge: ddr_wdone arrives together with the last beat.
    task automatic do_burst(input int pre, input int gap, input bit merge);
        int            g;
        int            beats;
        logic [AW-1:0] exp_addr;
        logic [LW-1:0] exp_len;
        logic [CH-1:0] oh;
        logic          wr;
        g = model_pick();
        if (g < 0) begin
            checks++;
            errors++;
            $display("FAIL burst_setup: got no eligible channel, required at least one");
            return;
        end
        exp_addr = addr[g];
        exp_len  = len[g];
        beats    = int'(exp_len);
        oh       = onehot(g);

        tick();
        cyc = 0;
        check("grant.wreq", ddr_wreq, 1'b1);
        check("grant.busy", busy, 1'b1);
        check("grant.id", grant_id, 3'(g));
        check("grant.waddr", ddr_waddr, exp_addr);
        check("grant.wr_len", ddr_wr_len, exp_len);

        for (int k = 0; k < pre; k++) begin
            ddr_wdata_req = 1'b0;
            addr[g] = AW'($urandom);
            len[g]  = LW'($urandom_range(1, 6));
            if ($urandom_range(0, 1) == 1) en[g] = 1'b0;
            rand_arrivals(g);
            randomize_data();
            #1;
            check("req.wreq_hold", ddr_wreq, 1'b1);
            check("req.waddr", ddr_waddr, exp_addr);
            check("req.wr_len", ddr_wr_len, exp_len);
            check("req.ch_wdreq", ch_wdata_req, '0);
            check("req.ddr_wdata", ddr_wdata, data[g]);
            burst_tick();
        end

        for (int b = 0; b < beats; b++) begin
            ddr_wdata_req = 1'b1;
            wr = 1'($urandom_range(0, 1));
            ddr_wrdy  = wr;
            ddr_wdone = merge && (b == beats - 1);
            if (b == 0) req[g] = 1'b0;
            addr[g] = AW'($urandom);
            rand_arrivals(g);
            randomize_data();
            #1;
            check("beat.ddr_wdata", ddr_wdata, data[g]);
            check("beat.ch_wdreq", ch_wdata_req, oh);
            check("beat.ch_wrdy", ch_wrdy, wr ? oh : '0);
            check("beat.ch_wdone", ch_wdone, ddr_wdone ? oh : '0);
            check("beat.waddr", ddr_waddr, exp_addr);
            if (b > 0) check("beat.wreq_low", ddr_wreq, 1'b0);
            burst_tick();
        end

        if (!merge) begin
            for (int k = 0; k < gap; k++) begin
                ddr_wdata_req = 1'b0;
                ddr_wdone     = 1'b0;
                rand_arrivals(g);
                randomize_data();
                #1;
                check("data.wreq_low", ddr_wreq, 1'b0);
                check("data.busy", busy, 1'b1);
                check("data.ch_wdreq", ch_wdata_req, '0);
                check("data.ddr_wdata", ddr_wdata, data[g]);
                burst_tick();
            end
            ddr_wdata_req = 1'b0;
            ddr_wdone     = 1'b1;
            #1;
            check("done.ch_wdone", ch_wdone, oh);
            check("done.waddr", ddr_waddr, exp_addr);
            burst_tick();
        end

        idle_ctrl();
        m_ptr = (g + 1) % CH;
        idle_check("after_burst");
        check("after_burst.grant_id", grant_id, 3'(g));
    endtask

    initial begin
        rst = 1'b1;
        req = '0;
        en  = '1;
        for (int c = 0; c < CH; c++) begin
            addr[c] = '0;
            len[c]  = LW'(1);
            data[c] = '0;
        end
        idle_ctrl();

        // Reset state.
        do_reset();

        // Single request on ch2, long burst.
        req = 4'b0100;
        addr[2] = AW'(32'h1000);
        len[2]  = LW'(160);
        do_burst(1, 1, 1'b0);

        // All four held: rotation from pointer 0.
        do_reset();
        for (int c = 0; c < CH; c++) begin
            addr[c] = AW'(32'h100 * (c + 1));
            len[c]  = LW'(c + 2);
        end
        for (int n = 0; n < 5; n++) begin
            req = '1;
            do_burst(n % 3, 1, 1'b0);
        end

        // ch1 disabled with every request high.
        do_reset();
        en = 4'b1101;
        for (int n = 0; n < 4; n++) begin
            req = '1;
            do_burst(1, 0, 1'b0);
        end

        // Data strobe and done on the same cycle while still in REQ.
        en = '1;
        req = 4'b0010;
        len[1] = LW'(1);
        do_burst(0, 0, 1'b1);

        // Randomized traffic.
        req = '0;
        for (int n = 0; n < 60; n++) begin
            for (int c = 0; c < CH; c++) begin
                if (!req[c] && $urandom_range(0, 1) == 1) begin
                    req[c]  = 1'b1;
                    addr[c] = AW'($urandom);
                    len[c]  = LW'($urandom_range(1, 6));
                end
                en[c] = ($urandom_range(0, 3) != 0);
            end
            if (model_pick() < 0) begin
                idle_check("no_eligible");
                tick();
                idle_check("no_eligible_hold");
                req[n % CH] = 1'b1;
                en[n % CH]  = 1'b1;
                len[n % CH] = LW'($urandom_range(1, 6));
            end
            do_burst($urandom_range(0, 3), $urandom_range(0, 2), ($urandom_range(0, 3) == 0));
        end

        // Timeout: ddr_wdone withheld well past TO cycles on ch2.
        req = 4'b0100;
        en  = '1;
        len[2] = LW'(1);
        do_burst(0, TO + 5, 1'b0);
        check("timeout_sticky", timeout_err, 1'b1);

        // Reset in the middle of a ch3 burst.
        req = 4'b1000;
        addr[3] = AW'(32'h2222);
        len[3]  = LW'(4);
        idle_ctrl();
        tick();
        check("rst_mid.grant_id", grant_id, 3'd3);
        ddr_wdata_req = 1'b1;
        tick();
        ddr_wdata_req = 1'b0;
        #1;
        check("rst_mid.data_busy", busy, 1'b1);
        rst = 1'b1;
        tick();
        rst   = 1'b0;
        m_ptr = 0;
        m_err = 1'b0;
        #1;
        check("rst_mid.wreq", ddr_wreq, 1'b0);
        check("rst_mid.busy", busy, 1'b0);
        check("rst_mid.grant_id", grant_id, 3'd0);
        check("rst_mid.waddr", ddr_waddr, '0);
        check("rst_mid.timeout_err", timeout_err, 1'b0);
        // ch3 still pending; ch0 joins. A cleared pointer serves ch0 first.
        req[0]  = 1'b1;
        addr[0] = AW'(32'h3333);
        len[0]  = LW'(2);
        do_burst(2, 1, 1'b0);
        do_burst(1, 1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
